// File: rtl/mul_copro_pkg.sv
// mul_copro_pkg: shared definitions for the multiply co-processor.
//   - default operand width and stack depth
//   - FSM state encoding used by the top-level sequencer
package mul_copro_pkg;

    localparam int W_DEF     = 32;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        MUL  = 3'd2,
        WLO  = 3'd3,
        WHI  = 3'd4
    } state_t;

endpackage

// File: rtl/mul_copro_lifo_stack.sv
// lifo_stack: register-array LIFO with occupancy count.
// Ports:
//   ck, rb        clock, asynchronous active-high reset (clears count only)
//   push, pop     single push / pop; both together replace the top
//                 (plain push when empty)
//   pop2          discard the two top entries (caller guarantees cnt >= 2)
//   din           push data
//   dout          top entry, 0 when empty
//   dnxt          entry below the top (valid when cnt >= 2)
//   cnt           entries held
//   full, empty   occupancy flags
// Overflowing pushes and underflowing pops are silently ignored here; the
// caller is responsible for flagging them.
module lifo_stack #(
    parameter int W     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       ck,
    input  logic                       rb,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       pop2,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [W-1:0]               dnxt,
    output logic [$clog2(DEPTH+1)-1:0] cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [CW-1:0] top_c;
    logic [CW-1:0] nxt_c;
    logic [AW-1:0] top_a;
    logic [AW-1:0] nxt_a;
    logic [AW-1:0] wr_a;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign top_c = cnt - CW'(1);
    assign nxt_c = cnt - CW'(2);
    assign top_a = top_c[AW-1:0];
    assign nxt_a = nxt_c[AW-1:0];
    assign wr_a  = cnt[AW-1:0];

    assign dout = empty ? '0 : mem[top_a];
    assign dnxt = mem[nxt_a];

    // Storage carries no reset: an empty count masks stale contents.
    always_ff @(posedge ck) begin
        if (push && pop && !empty) begin
            mem[top_a] <= din;
        end else if (push && !pop && !full) begin
            mem[wr_a] <= din;
        end else if (push && pop && empty) begin
            mem[wr_a] <= din;
        end
    end

    always_ff @(posedge ck or posedge rb) begin
        if (rb) begin
            cnt <= '0;
        end else if (pop2) begin
            cnt <= cnt - CW'(2);
        end else if (push && pop) begin
            if (empty) cnt <= cnt + CW'(1);
        end else if (push && !full) begin
            cnt <= cnt + CW'(1);
        end else if (pop && !empty) begin
            cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/mul_copro.sv
// mul_copro: operand stack plus sequential shift-add multiplier.
// Ports:
//   rb, ck        asynchronous active-high reset, clock
//   start, sgn    begin multiply (sampled while ready), signed mode
//   ready         idle indication
//   dpsh, dinp    push request and data
//   dpop          pop request
//   dout          top of stack (0 when empty)
//   err, eclr     sticky error flag and its synchronous clear
//   cnt           entries held
// A multiply pops B (top) and A (next), then pushes low word and high word
// of A*B, leaving the high word on top.
module mul_copro
    import mul_copro_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                       rb,
    input  logic                       ck,
    input  logic                       start,
    input  logic                       sgn,
    output logic                       ready,
    input  logic                       dpsh,
    input  logic [W-1:0]               dinp,
    input  logic                       dpop,
    output logic [W-1:0]               dout,
    output logic                       err,
    input  logic                       eclr,
    output logic [$clog2(DEPTH+1)-1:0] cnt
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int BW = $clog2(W);

    state_t            state, nstate;
    logic              sgn_r;
    logic              neg;
    logic [W-1:0]      mcand;
    logic [W-1:0]      mplier;
    logic [2*W-1:0]    acc;
    logic [BW-1:0]     bitcnt;

    logic              stk_push, stk_pop, stk_pop2;
    logic [W-1:0]      stk_din;
    logic [W-1:0]      stk_nxt;
    logic              stk_full, stk_empty;
    logic signed [W-1:0] a_s, b_s;

    logic              idle, go, err_ev;
    logic [W:0]        sum;
    logic [2*W-1:0]    acc_step;
    logic [2*W-1:0]    prod_fix;

    // Magnitude of a two's-complement word; -2^(W-1) maps to 2^(W-1),
    // which still fits as an unsigned W-bit value.
    function automatic logic [W-1:0] mag(input logic signed [W-1:0] x);
        mag = x[W-1] ? $unsigned(-x) : $unsigned(x);
    endfunction

    function automatic logic [2*W-1:0] neg2w(input logic [2*W-1:0] p);
        neg2w = (~p) + (2*W)'(1);
    endfunction

    lifo_stack #(.W(W), .DEPTH(DEPTH)) u_stack (
        .ck    (ck),
        .rb    (rb),
        .push  (stk_push),
        .pop   (stk_pop),
        .pop2  (stk_pop2),
        .din   (stk_din),
        .dout  (dout),
        .dnxt  (stk_nxt),
        .cnt   (cnt),
        .full  (stk_full),
        .empty (stk_empty)
    );

    assign idle  = (state == IDLE);
    assign ready = idle;
    assign go    = idle && start && (cnt >= CW'(2));
    assign b_s   = $signed(dout);
    assign a_s   = $signed(stk_nxt);

    // One shift-add step: add the multiplicand into the upper half when the
    // current multiplier bit is set, then shift the whole accumulator right.
    assign sum      = {1'b0, acc[2*W-1:W]} + {1'b0, (mplier[0] ? mcand : '0)};
    assign acc_step = {sum, acc[W-1:1]};
    assign prod_fix = neg ? neg2w(acc) : acc;

    always_comb begin
        nstate   = state;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_pop2 = 1'b0;
        stk_din  = dinp;
        case (state)
            IDLE: begin
                if (go) begin
                    nstate = LOAD;
                end else begin
                    stk_push = dpsh;
                    stk_pop  = dpop;
                end
            end
            LOAD: begin
                stk_pop2 = 1'b1;
                nstate   = MUL;
            end
            MUL: begin
                if (bitcnt == BW'(W-1)) nstate = WLO;
            end
            WLO: begin
                stk_push = 1'b1;
                stk_din  = prod_fix[W-1:0];
                nstate   = WHI;
            end
            WHI: begin
                stk_push = 1'b1;
                stk_din  = acc[2*W-1:W];
                nstate   = IDLE;
            end
            default: nstate = IDLE;
        endcase
    end

    // Error sources: stack traffic while busy or alongside an accepted start,
    // a start without two operands, and overflow/underflow of single ops.
    always_comb begin
        err_ev = 1'b0;
        if (!idle && (dpsh || dpop)) err_ev = 1'b1;
        if (idle && start && (cnt < CW'(2))) err_ev = 1'b1;
        if (go && (dpsh || dpop)) err_ev = 1'b1;
        if (idle && !go && dpsh && !dpop && stk_full) err_ev = 1'b1;
        if (idle && !go && dpop && !dpsh && stk_empty) err_ev = 1'b1;
    end

    always_ff @(posedge ck or posedge rb) begin
        if (rb) begin
            state <= IDLE;
            err   <= 1'b0;
        end else begin
            state <= nstate;
            if (err_ev)    err <= 1'b1;
            else if (eclr) err <= 1'b0;
        end
    end

    always_ff @(posedge ck or posedge rb) begin
        if (rb) begin
            sgn_r  <= 1'b0;
            neg    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            bitcnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) sgn_r <= sgn;
                end
                LOAD: begin
                    acc    <= '0;
                    bitcnt <= '0;
                    if (sgn_r) begin
                        mcand  <= mag(a_s);
                        mplier <= mag(b_s);
                        neg    <= a_s[W-1] ^ b_s[W-1];
                    end else begin
                        mcand  <= stk_nxt;
                        mplier <= dout;
                        neg    <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_step;
                    mplier <= mplier >> 1;
                    bitcnt <= bitcnt + BW'(1);
                end
                WLO: begin
                    acc <= prod_fix;
                end
                default: ;
            endcase
        end
    end

endmodule
